// File: rtl/ip_lms2oklab_if.sv
// ip_lms2oklab_if
//   Pixel stream bundle for the LMS -> OKLab converter.
//   i_data_l/m/s : LMS cone response, unsigned 8.6
//   i_hstr/href/hend : line-start, line-valid, line-end syncs
//   o_data_l : OKLab L, unsigned 3.10
//   o_data_a_sgn/o_data_b_sgn : OKLab a/b, signed 2.11
//   o_hstr/href/hend : syncs aligned with the output pixel
//   master = pixel source/sink side, slave = converter side.
interface ip_lms2oklab_if #(
    parameter int CIW    = 14,
    parameter int COW_L  = 13,
    parameter int COW_AB = 13
);
    logic [CIW-1:0]    i_data_l;
    logic [CIW-1:0]    i_data_m;
    logic [CIW-1:0]    i_data_s;
    logic              i_hstr;
    logic              i_href;
    logic              i_hend;
    logic [COW_L-1:0]  o_data_l;
    logic [COW_AB-1:0] o_data_a_sgn;
    logic [COW_AB-1:0] o_data_b_sgn;
    logic              o_hstr;
    logic              o_href;
    logic              o_hend;

    modport master (
        output i_data_l, i_data_m, i_data_s, i_hstr, i_href, i_hend,
        input  o_data_l, o_data_a_sgn, o_data_b_sgn, o_hstr, o_href, o_hend
    );

    modport slave (
        input  i_data_l, i_data_m, i_data_s, i_hstr, i_href, i_hend,
        output o_data_l, o_data_a_sgn, o_data_b_sgn, o_hstr, o_href, o_hend
    );
endinterface

// File: rtl/ip_lms2oklab.sv
// ip_lms2oklab
//   Free-running 18-stage pipeline converting linear LMS to OKLab:
//   stage 0 input register, stages 1-15 per-channel digit-serial cube
//   root (3 radicand bits per stage), stage 16 matrix sums, stage 17
//   round/shift/clip into the output registers.
//   Ports: clk, rst_n (async, active-low), bus (ip_lms2oklab_if.slave).
module ip_lms2oklab #(
    parameter int CIW    = 14,
    parameter int COW_L  = 13,
    parameter int COW_AB = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    ip_lms2oklab_if.slave  bus
);
    localparam int LATENCY = 18;
    localparam int NST     = 15;          // root stages, one result bit each
    localparam int RADW    = 45;          // (CIW << 30) padded to 15 x 3 bits
    localparam int RW      = 40;          // remainder; peak is below 2^36
    localparam int YW      = 15;          // root, unsigned 3.12
    localparam int L_MAX   = (2 ** COW_L) - 1;
    localparam int AB_MAX  = (2 ** (COW_AB - 1)) - 1;
    localparam int AB_MIN  = -(2 ** (COW_AB - 1));

    // stage 0
    logic [CIW-1:0]  pix_q [3];

    // stages 1..15
    logic [RADW-1:0] rad_q  [3][NST];
    logic [RW-1:0]   rem_q  [3][NST];
    logic [YW-1:0]   root_q [3][NST];
    logic [RADW-1:0] rad_n  [3][NST];
    logic [RW-1:0]   rem_n  [3][NST];
    logic [YW-1:0]   root_n [3][NST];

    // stage 16 / 17
    logic signed [31:0] sum_l_q, sum_a_q, sum_b_q;
    logic signed [31:0] sum_l_n, sum_a_n, sum_b_n;
    logic [COW_L-1:0]   out_l_q, out_l_n;
    logic [COW_AB-1:0]  out_a_q, out_a_n, out_b_q, out_b_n;

    logic [LATENCY-1:0] q_hstr, q_href, q_hend;

    always_comb begin
        logic [RADW-1:0] rp;
        logic [RW-1:0]   mp, r_t, t_t, y2w;
        logic [YW-1:0]   yp, y2;
        int              kp;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < NST; k++) begin
                kp = (k == 0) ? 0 : k - 1;
                if (k == 0) begin
                    rp = {1'b0, pix_q[c], 30'b0};
                    mp = '0;
                    yp = '0;
                end else begin
                    rp = rad_q[c][kp];
                    mp = rem_q[c][kp];
                    yp = root_q[c][kp];
                end
                r_t = {mp[RW-4:0], rp[RADW-1 -: 3]};
                y2  = {yp[YW-2:0], 1'b0};
                y2w = RW'(y2);
                t_t = 3 * y2w * (y2w + 1) + 1;
                rad_n[c][k] = {rp[RADW-4:0], 3'b000};
                if (r_t >= t_t) begin
                    rem_n[c][k]  = r_t - t_t;
                    root_n[c][k] = y2 | YW'(1);
                end else begin
                    rem_n[c][k]  = r_t;
                    root_n[c][k] = y2;
                end
            end
        end
    end

    always_comb begin
        logic signed [31:0] rl, rm, rs;
        rl = $signed({17'd0, root_q[0][NST-1]});
        rm = $signed({17'd0, root_q[1][NST-1]});
        rs = $signed({17'd0, root_q[2][NST-1]});
        sum_l_n = 32'sd431  * rl + 32'sd1625 * rm - 32'sd8    * rs;
        sum_a_n = 32'sd4051 * rl - 32'sd4974 * rm + 32'sd923  * rs;
        sum_b_n = 32'sd53   * rl + 32'sd1603 * rm - 32'sd1656 * rs;
    end

    always_comb begin
        logic signed [31:0] rnd_l, rnd_a, rnd_b;
        rnd_l = (sum_l_q + 32'sd4096) >>> 13;
        rnd_a = (sum_a_q + 32'sd2048) >>> 12;
        rnd_b = (sum_b_q + 32'sd2048) >>> 12;

        if (rnd_l < 0)           out_l_n = '0;
        else if (rnd_l > L_MAX)  out_l_n = COW_L'(L_MAX);
        else                     out_l_n = rnd_l[COW_L-1:0];

        if (rnd_a < AB_MIN)      out_a_n = COW_AB'(AB_MIN);
        else if (rnd_a > AB_MAX) out_a_n = COW_AB'(AB_MAX);
        else                     out_a_n = rnd_a[COW_AB-1:0];

        if (rnd_b < AB_MIN)      out_b_n = COW_AB'(AB_MIN);
        else if (rnd_b > AB_MAX) out_b_n = COW_AB'(AB_MAX);
        else                     out_b_n = rnd_b[COW_AB-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                pix_q[c] <= '0;
                for (int k = 0; k < NST; k++) begin
                    rad_q[c][k]  <= '0;
                    rem_q[c][k]  <= '0;
                    root_q[c][k] <= '0;
                end
            end
            sum_l_q <= '0;
            sum_a_q <= '0;
            sum_b_q <= '0;
            out_l_q <= '0;
            out_a_q <= '0;
            out_b_q <= '0;
            q_hstr  <= '0;
            q_href  <= '0;
            q_hend  <= '0;
        end else begin
            pix_q[0] <= bus.i_data_l;
            pix_q[1] <= bus.i_data_m;
            pix_q[2] <= bus.i_data_s;
            for (int c = 0; c < 3; c++) begin
                for (int k = 0; k < NST; k++) begin
                    rad_q[c][k]  <= rad_n[c][k];
                    rem_q[c][k]  <= rem_n[c][k];
                    root_q[c][k] <= root_n[c][k];
                end
            end
            sum_l_q <= sum_l_n;
            sum_a_q <= sum_a_n;
            sum_b_q <= sum_b_n;
            out_l_q <= out_l_n;
            out_a_q <= out_a_n;
            out_b_q <= out_b_n;
            q_hstr  <= {q_hstr[LATENCY-2:0], bus.i_hstr};
            q_href  <= {q_href[LATENCY-2:0], bus.i_href};
            q_hend  <= {q_hend[LATENCY-2:0], bus.i_hend};
        end
    end

    // The last root stage's leftover radicand and remainder are not needed.
    logic unused_tail;
    assign unused_tail = ^{rad_q[0][NST-1], rad_q[1][NST-1], rad_q[2][NST-1],
                           rem_q[0][NST-1], rem_q[1][NST-1], rem_q[2][NST-1]};

    assign bus.o_data_l     = out_l_q;
    assign bus.o_data_a_sgn = out_a_q;
    assign bus.o_data_b_sgn = out_b_q;
    assign bus.o_hstr       = q_hstr[LATENCY-1];
    assign bus.o_href       = q_href[LATENCY-1];
    assign bus.o_hend       = q_hend[LATENCY-1];
endmodule

// File: tb/tb_ip_lms2oklab.sv
module tb_ip_lms2oklab;
    localparam int LATENCY = 18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ip_lms2oklab_if bus ();

    ip_lms2oklab dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [12:0] l, a, b;
        logic        hs, hr, he;
        bit          lit;
        logic [12:0] ll, la, lb;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, act, exp);
        end
    endtask

    // Largest y with y^3 <= n, by bisection.
    function automatic longint cbrt_floor(input longint n);
        longint lo, hi, mid;
        lo = 0;
        hi = 32767;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid * mid <= n) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic longint clip(input longint v, input longint lo, input longint hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic exp_t model(input int l, input int m, input int s,
                                   input logic hs, input logic hr, input logic he);
        exp_t   e;
        longint rl, rm, rs, sl, sa, sb;
        rl = cbrt_floor(longint'(l) * 64'd1073741824);
        rm = cbrt_floor(longint'(m) * 64'd1073741824);
        rs = cbrt_floor(longint'(s) * 64'd1073741824);
        sl = 431 * rl + 1625 * rm - 8 * rs;
        sa = 4051 * rl - 4974 * rm + 923 * rs;
        sb = 53 * rl + 1603 * rm - 1656 * rs;
        e.l  = 13'(clip((sl + 4096) >>> 13, 0, 8191));
        e.a  = 13'(clip((sa + 2048) >>> 12, -4096, 4095));
        e.b  = 13'(clip((sb + 2048) >>> 12, -4096, 4095));
        e.hs = hs; e.hr = hr; e.he = he;
        e.lit = 1'b0; e.ll = '0; e.la = '0; e.lb = '0;
        return e;
    endfunction

    function automatic exp_t zero_entry();
        exp_t e;
        e = model(0, 0, 0, 1'b0, 1'b0, 1'b0);
        return e;
    endfunction

    task automatic prefill();
        exp_q.delete();
        for (int i = 0; i < LATENCY - 1; i++) exp_q.push_back(zero_entry());
    endtask

    task automatic check_outputs(input exp_t e);
        check_val("o_data_l",     32'(bus.o_data_l),     32'(e.l));
        check_val("o_data_a_sgn", 32'(bus.o_data_a_sgn), 32'(e.a));
        check_val("o_data_b_sgn", 32'(bus.o_data_b_sgn), 32'(e.b));
        check_val("o_hstr",       32'(bus.o_hstr),       32'(e.hs));
        check_val("o_href",       32'(bus.o_href),       32'(e.hr));
        check_val("o_hend",       32'(bus.o_hend),       32'(e.he));
        if (e.lit) begin
            check_val("known_l", 32'(bus.o_data_l),     32'(e.ll));
            check_val("known_a", 32'(bus.o_data_a_sgn), 32'(e.la));
            check_val("known_b", 32'(bus.o_data_b_sgn), 32'(e.lb));
        end
    endtask

    // Called at a negedge: drive one pixel, clock it, check the pixel leaving.
    task automatic pixel(input int l, input int m, input int s,
                         input logic hs, input logic hr, input logic he,
                         input bit lit, input int ll, input int la, input int lb);
        exp_t e;
        bus.i_data_l = 14'(l);
        bus.i_data_m = 14'(m);
        bus.i_data_s = 14'(s);
        bus.i_hstr = hs;
        bus.i_href = hr;
        bus.i_hend = he;
        e = model(l, m, s, hs, hr, he);
        e.lit = lit;
        e.ll = 13'(ll); e.la = 13'(la); e.lb = 13'(lb);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs(exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pixel(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_l"},  32'(bus.o_data_l),     32'd0);
        check_val({tag, "_a"},  32'(bus.o_data_a_sgn), 32'd0);
        check_val({tag, "_b"},  32'(bus.o_data_b_sgn), 32'd0);
        check_val({tag, "_hs"}, 32'(bus.o_hstr),       32'd0);
        check_val({tag, "_hr"}, 32'(bus.o_href),       32'd0);
        check_val({tag, "_he"}, 32'(bus.o_hend),       32'd0);
    endtask

    initial begin
        int l, m, s, sel;
        logic hs, hr, he;
        bus.i_data_l = '0; bus.i_data_m = '0; bus.i_data_s = '0;
        bus.i_hstr = 1'b0; bus.i_href = 1'b0; bus.i_hend = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        prefill();

        // Known operating points
        pixel(64, 64, 64,       1'b1, 1'b1, 1'b0, 1'b1, 1024, 0, 0);
        pixel(0, 0, 0,          1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        pixel(512, 512, 512,    1'b0, 1'b1, 1'b0, 1'b1, 2048, 0, 0);
        pixel(16383, 0, 0,      1'b0, 1'b1, 1'b1, 1'b1, 1368, 4095, 337);
        idle(3);
        // 4-pixel line then a 1-pixel line (hstr and hend together)
        pixel(100, 200, 300,    1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        pixel(16383, 16383, 16383, 1'b0, 1'b1, 1'b0, 1'b1, 6502, 0, 0);
        pixel(0, 0, 16383,      1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        pixel(7, 9000, 1,       1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        idle(2);
        pixel(1234, 1234, 1234, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        idle(LATENCY + 2);

        // Random back-to-back stream with a one-cycle reset in the middle
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("midreset");
                @(posedge clk);
                @(negedge clk);
                check_all_zero("midreset_hold");
                rst_n = 1'b1;
                prefill();
            end
            sel = $urandom_range(0, 7);
            l = $urandom_range(0, 16383);
            m = $urandom_range(0, 16383);
            s = $urandom_range(0, 16383);
            if (sel == 0) begin m = l; s = l; end
            else if (sel == 1) begin
                l = ($urandom_range(0, 1) != 0) ? 16383 : 0;
                m = ($urandom_range(0, 1) != 0) ? 16383 : 0;
                s = ($urandom_range(0, 1) != 0) ? 16383 : 0;
            end else if (sel == 2) begin
                l = $urandom_range(0, 128);
                m = $urandom_range(0, 128);
                s = $urandom_range(0, 128);
            end
            hs = ($urandom_range(0, 15) == 0);
            hr = ($urandom_range(0, 3) != 0);
            he = ($urandom_range(0, 15) == 0);
            pixel(l, m, s, hs, hr, he, 1'b0, 0, 0, 0);
        end
        idle(LATENCY + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ip_lms2oklab.md
IP_LMS2OKLAB -- requirements
Module: ip_lms2oklab

Interface
REQ-001 Parameter CIW, default 14: LMS input width, unsigned 8.6; only the default is supported.
REQ-002 Parameter COW_L, default 13: L output width, unsigned 3.10.
REQ-003 Parameter COW_AB, default 13: a/b output width, signed 2.11 (two's complement).
REQ-004 Localparam LATENCY, fixed 18: data and sync latency in clk cycles.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 i_data_l, i_data_m, i_data_s  input  14 each  LMS (linear cone response), unsigned 8.6.
REQ-008 i_hstr, i_href, i_hend  input  1 each  line-start, line-valid and line-end syncs.
REQ-009 o_data_l  output  13  OKLab L, unsigned 3.10, registered.
REQ-010 o_data_a_sgn, o_data_b_sgn  output  13 each  OKLab a/b, signed 2.11, registered.
REQ-011 o_hstr, o_href, o_hend  output  1 each  input syncs delayed by LATENCY.

Function
REQ-012 The pipeline shall be free-running: one pixel accepted and one produced every cycle, with no stall or backpressure; data on cycles with i_href=0 is processed but is don't-care.
REQ-013 Stage 0 shall register the three inputs.
REQ-014 Stages 1-15 shall each compute one result bit of an unsigned cube root per channel: radicand = input<<30, zero-padded to 45 bits, consumed 3 bits per stage MSB first; result width 15 bits, unsigned 3.12.
REQ-015 Each root stage shall apply: r = (r<<3)|next3; y2 = 2y; t = 3*y2*(y2+1)+1; if r >= t then r = r-t and y = y2+1, else y = y2; remainder width shall never overflow.
REQ-016 The cube root shall be floor-exact: root(64)=4096, root(512)=8192, root(0)=0, root(16383)=26007.
REQ-017 Stage 16 shall register the matrix sums, with coefficients in /2048 units: L = 431l + 1625m - 8s; a = 4051l - 4974m + 923s; b = 53l + 1603m - 1656s; signed accumulators at least 30 bits wide.
REQ-018 Stage 17 shall round half-up and shift: L = (sumL + 2^12) >>> 13; a,b = (sum + 2^11) >>> 12.
REQ-019 Stage 17 shall clip L to [0, 8191] and a,b to [-4096, 4095], and register the result to the outputs.
REQ-020 Sync outputs shall come from a 3x18-bit shift queue; o_hstr, o_href and o_hend shall be cycle-aligned with the data they accompany.
REQ-021 Neutral inputs (l=m=s) shall give a=b=0 exactly, because the coefficients of each of a and b sum to zero.
REQ-022 Simultaneous i_hstr and i_hend, as in a 1-pixel line, shall propagate unchanged.

Reset
REQ-023 On rst_n=0 all pipeline registers, the sync queue and all outputs shall clear to 0 asynchronously.
REQ-024 After rst_n rises, outputs shall stay 0 for LATENCY cycles; syncs shall remain 0 until propagated inputs arrive.
REQ-025 An assertion of rst_n mid-line shall discard all in-flight pixels; no partial sync pulse shall be emitted after release.

Verification
REQ-026 l=m=s=64 (1.0) -> o_data_l=1024, a=0, b=0, 18 cycles later.
REQ-027 l=m=s=0 -> L=0, a=0, b=0; l=m=s=512 -> L=2048, a=0, b=0.
REQ-028 l=16383, m=0, s=0 -> L=1368, a=4095 (clipped), b=337.
REQ-029 Single-cycle i_hstr at cycle N, i_href high for 4 cycles, i_hend at N+3 -> o_hstr at N+18, o_href for cycles N+18..N+21, o_hend at N+21, each aligned with its pixel's data.
REQ-030 Back-to-back random LMS stream of 10k pixels -> every output matches a bit-exact reference model, one result per cycle.
REQ-031 rst_n pulsed low for 1 cycle mid-stream -> all outputs 0 immediately; only post-reset pixels appear, first at release+18.
